sprite_engine: RTL

SPRITE_ENGINE -- requirements
Module: sprite_engine

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_addr_gen.sv | 66 ++++++
 rtl/sprite_engine.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and palette decode for the sprite renderer.
// Palette index 0 is the transparent colour.
package sprite_pkg;

  typedef logic [7:0] pix_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam pix_t TRANSPARENT = pix_t'(0);

  // Low three index bits select primaries; high bits tint red.
  function automatic rgb_t pal_rgb(input pix_t i);
    rgb_t c;
    c.r = {8{i[2]}} ^ {i[7:3], 3'b000};
    c.g = {8{i[1]}};
    c.b = {8{i[0]}};
    return c;
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Stage 1: box test, 2x scaling, mirror and ROM address.
// Registers address, in_box and a post-reset valid bit.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 64,
  parameter int NUM_FRAMES = 4,
  localparam int AW = $clog2(NUM_FRAMES*SPR_W*SPR_H),
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    pixelx,
  input  logic [9:0]    pixely,
  input  logic [9:0]    sx,
  input  logic [9:0]    sy,
  input  logic          flip,
  input  logic          scale,
  input  logic [FW-1:0] fidx,
  output logic [AW-1:0] addr,
  output logic          in_box,
  output logic          valid
);

  localparam int XW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int YW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  logic [10:0]   dx;
  logic [10:0]   dy;
  logic [10:0]   weff;
  logic [10:0]   heff;
  logic [XW-1:0] lxr;
  logic [XW-1:0] lx;
  logic [YW-1:0] ly;
  logic          box;
  logic [AW-1:0] addr_d;

  // Unsigned wrap makes points left of / above the box huge.
  always_comb begin
    dx     = {1'b0, pixelx} - {1'b0, sx};
    dy     = {1'b0, pixely} - {1'b0, sy};
    weff   = 11'(SPR_W) << scale;
    heff   = 11'(SPR_H) << scale;
    box    = (dx < weff) && (dy < heff);
    lxr    = XW'(dx >> scale);
    ly     = YW'(dy >> scale);
    lx     = flip ? ~lxr : lxr;
    addr_d = AW'(fidx) * AW'(SPR_W*SPR_H)
           + AW'(ly) * AW'(SPR_W)
           + AW'(lx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= '0;
      in_box <= 1'b0;
      valid  <= 1'b0;
    end else begin
      addr   <= addr_d;
      in_box <= box;
      valid  <= 1'b1;
    end
  end

endmodule

// File: rtl/sprite_engine.sv
// Animated sprite renderer: shadowed position, frame divider,
// three-stage address / ROM / palette pipeline.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 64,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_DIV  = 8,
  parameter int COLOR_BITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [9:0] posx,
  input  logic [9:0] posy,
  input  logic [9:0] pixelx,
  input  logic [9:0] pixely,
  input  logic       anim_en,
  input  logic       flip_x,
  input  logic       scale2,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic       visible
);

  localparam int AW  = $clog2(NUM_FRAMES*SPR_W*SPR_H);
  localparam int FW  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int FSH = $clog2(SPR_W*SPR_H);

  logic [9:0]            sx;
  logic [9:0]            sy;
  logic                  sflip;
  logic                  sscale;
  logic [7:0]            div_cnt;
  logic [7:0]            div_nxt;
  logic [FW-1:0]         fidx;
  logic [AW-1:0]         addr1;
  logic                  box1;
  logic                  v1;
  logic [COLOR_BITS-1:0] rom_q;
  logic                  box2;
  logic                  v2;
  pix_t                  pix;
  rgb_t                  rgb;
  logic                  opaque;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx     <= '0;
      sy     <= '0;
      sflip  <= 1'b0;
      sscale <= 1'b0;
    end else if (frame_start) begin
      sx     <= posx;
      sy     <= posy;
      sflip  <= flip_x;
      sscale <= scale2;
    end
  end

  assign div_nxt = (div_cnt == 8'(FRAME_DIV-1)) ? 8'd0 : div_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      fidx    <= '0;
    end else if (frame_start && anim_en) begin
      div_cnt <= div_nxt;
      if (div_nxt == 8'(FRAME_DIV-1)) begin
        fidx <= (fidx == FW'(NUM_FRAMES-1)) ? '0 : fidx + 1'b1;
      end
    end
  end

  sprite_addr_gen #(
    .SPR_W     (SPR_W),
    .SPR_H     (SPR_H),
    .NUM_FRAMES(NUM_FRAMES)
  ) u_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .pixelx(pixelx),
    .pixely(pixely),
    .sx    (sx),
    .sy    (sy),
    .flip  (sflip),
    .scale (sscale),
    .fidx  (fidx),
    .addr  (addr1),
    .in_box(box1),
    .valid (v1)
  );

  // Procedural ROM image: pixel bits tinted by the frame number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_q <= '0;
      box2  <= 1'b0;
      v2    <= 1'b0;
    end else begin
      rom_q <= COLOR_BITS'(addr1 ^ (addr1 >> FSH));
      box2  <= box1 && v1;
      v2    <= v1;
    end
  end

  always_comb begin
    pix    = pix_t'(rom_q);
    opaque = v2 && box2 && (pix != TRANSPARENT);
    rgb    = pal_rgb(pix);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Red     <= '0;
      Green   <= '0;
      Blue    <= '0;
      visible <= 1'b0;
    end else begin
      Red     <= opaque ? rgb.r : 8'd0;
      Green   <= opaque ? rgb.g : 8'd0;
      Blue    <= opaque ? rgb.b : 8'd0;
      visible <= opaque;
    end
  end

endmodule
